// File: rtl/rsr_shift_add_ctrl.sv
// ---------------------------------------------------------------------------
// rsr_shift_add_ctrl
//
// Sequencer for the shift-right operand register of a shift-and-add
// multiplier. After a start request it loads the operand and clears the
// accumulator. It then issues one shift per cycle, and adds into the
// accumulator on every shift where the register LSB is 1. The operation ends
// after N shifts, or earlier once the register has drained to zero when
// EARLY_EXIT is set.
//
// Parameters
//   N          operand register width = maximum number of shifts
//   CNT_W      step counter width, 2**CNT_W must exceed N
//   EARLY_EXIT 1: stop as soon as reg_zero is seen in RUN
//              0: always perform exactly N shifts
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset (0 = reset)
//   start       in   request a new operation; honoured in IDLE and DONE
//   abort       in   synchronous cancel back to IDLE, no done pulse
//   reg_lsb     in   data_out[0] of the operand register
//   reg_zero    in   operand register currently holds zero
//   load_en     out  load strobe to the operand register
//   shift_en    out  shift strobe to the operand register
//   acc_clr     out  clear the accumulator
//   acc_add_en  out  add (multiplicand << step_cnt) into the accumulator
//   step_cnt    out  shifts already issued in this operation
//   busy        out  operation in progress (LOAD or RUN)
//   done        out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module rsr_shift_add_ctrl #(
    parameter int N          = 14,
    parameter int CNT_W      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             reg_lsb,
    input  logic             reg_zero,
    output logic             load_en,
    output logic             shift_en,
    output logic             acc_clr,
    output logic             acc_add_en,
    output logic [CNT_W-1:0] step_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] MAX_STEP  = CNT_W'(N);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // The step count tops out at N; saturating keeps a stray extra increment
    // from ever wrapping the counter back to a small value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= MAX_STEP) begin
            return MAX_STEP;
        end
        return v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        acc_clr    = 1'b0;
        acc_add_en = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                load_en   = 1'b1;
                acc_clr   = 1'b1;
                busy      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = S_RUN;
            end

            S_RUN: begin
                busy = 1'b1;
                // A drained register contributes nothing further, so stop
                // without spending a shift on it.
                if (EARLY_EXIT && reg_zero) begin
                    state_nxt = S_DONE;
                end else begin
                    shift_en   = 1'b1;
                    acc_add_en = reg_lsb;
                    cnt_nxt    = sat_inc(cnt);
                    if (cnt == LAST_STEP) begin
                        state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done = 1'b1;
                // Counter is held through DONE so the final step count is
                // visible alongside the pulse; it restarts from zero after.
                cnt_nxt = '0;
                if (start) begin
                    state_nxt = S_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Cancel overrides every strobe in the same cycle, including a
        // pending done pulse; busy still reflects the state being left.
        if (abort) begin
            load_en    = 1'b0;
            shift_en   = 1'b0;
            acc_clr    = 1'b0;
            acc_add_en = 1'b0;
            done       = 1'b0;
            state_nxt  = S_IDLE;
            cnt_nxt    = '0;
        end
    end

    assign step_cnt = cnt;

endmodule

// File: tb/tb_rsr_shift_add_ctrl.sv
module tb_rsr_shift_add_ctrl;

    localparam int N     = 14;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic abort;
    logic ee;
    logic [N-1:0] operand;

    always #5 clk = ~clk;

    // Two instances: one with early exit, one always doing N shifts.
    logic start1, abort1, start0, abort0;
    assign start1 = start & ee;
    assign abort1 = abort & ee;
    assign start0 = start & ~ee;
    assign abort0 = abort & ~ee;

    logic             ld1, sh1, clr1, add1, busy1, done1;
    logic             ld0, sh0, clr0, add0, busy0, done0;
    logic [CNT_W-1:0] cnt1, cnt0;
    logic [N-1:0]     sr1 = '0;
    logic [N-1:0]     sr0 = '0;

    rsr_shift_add_ctrl #(.N(N), .CNT_W(CNT_W), .EARLY_EXIT(1'b1)) u_ee1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .reg_lsb(sr1[0]), .reg_zero(sr1 == '0),
        .load_en(ld1), .shift_en(sh1), .acc_clr(clr1), .acc_add_en(add1),
        .step_cnt(cnt1), .busy(busy1), .done(done1)
    );

    rsr_shift_add_ctrl #(.N(N), .CNT_W(CNT_W), .EARLY_EXIT(1'b0)) u_ee0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .reg_lsb(sr0[0]), .reg_zero(sr0 == '0),
        .load_en(ld0), .shift_en(sh0), .acc_clr(clr0), .acc_add_en(add0),
        .step_cnt(cnt0), .busy(busy0), .done(done0)
    );

    // Behavioural operand registers driven by the controllers.
    always @(posedge clk) begin
        if (ld1) sr1 <= operand;
        else if (sh1) sr1 <= sr1 >> 1;
        if (ld0) sr0 <= operand;
        else if (sh0) sr0 <= sr0 >> 1;
    end

    // Observed vector: [9]load [8]shift [7]clr [6]add [5]busy [4]done [3:0]cnt
    logic [9:0] obs;
    assign obs = ee ? {ld1, sh1, clr1, add1, busy1, done1, cnt1}
                    : {ld0, sh0, clr0, add0, busy0, done0, cnt0};

    int errors = 0;
    int checks = 0;

    function automatic logic [9:0] mk(input bit l, input bit s, input bit c,
                                      input bit a, input bit b, input bit d,
                                      input int cnt);
        logic [3:0] c4;
        c4 = cnt[3:0];
        return {l, s, c, a, b, d, c4};
    endfunction

    function automatic int bitlen(input logic [N-1:0] v);
        int b;
        b = 0;
        for (int i = 0; i < N; i++) if (v[i]) b = i + 1;
        return b;
    endfunction

    // Reference: an operation is one LOAD cycle, one cycle per shift with the
    // accumulate strobe equal to operand bit i, an extra zero-detect cycle when
    // early exit stops before N shifts, then the DONE cycle.
    // Caller raises start just after an edge; the next edge samples it.
    task automatic check_op(input bit e, input logic [N-1:0] v, input bit keep,
                            input string name);
        logic [9:0] expq[$];
        logic [9:0] mskq[$];
        int s;
        s = e ? bitlen(v) : N;
        expq.push_back(mk(1, 0, 1, 0, 1, 0, 0));
        mskq.push_back(10'h3F0);
        for (int i = 0; i < s; i++) begin
            expq.push_back(mk(0, 1, 0, v[i], 1, 0, i));
            mskq.push_back(10'h3FF);
        end
        if (e && s < N) begin
            expq.push_back(mk(0, 0, 0, 0, 1, 0, s));
            mskq.push_back(10'h3FF);
        end
        expq.push_back(mk(0, 0, 0, 0, 0, 1, s));
        mskq.push_back(10'h3FF);
        for (int j = 0; j < expq.size(); j++) begin
            @(posedge clk); #1;
            checks++;
            if ((obs & mskq[j]) !== (expq[j] & mskq[j])) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b (mask %b)",
                         name, j, obs, expq[j], mskq[j]);
            end
            if (j == 0 && !keep) start = 1'b0;
        end
        if (!keep) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== 10'h000) begin
                errors++;
                $display("FAIL %s idle_after: got %b expected %b", name, obs, 10'h000);
            end
        end
    endtask

    task automatic test_reset();
        ee = 1'b1; #1;
        checks++;
        if (obs !== 10'h000) begin
            errors++;
            $display("FAIL reset_ee1: got %b expected %b", obs, 10'h000);
        end
        ee = 1'b0; #1;
        checks++;
        if (obs !== 10'h000) begin
            errors++;
            $display("FAIL reset_ee0: got %b expected %b", obs, 10'h000);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== 10'h000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected %b", obs, 10'h000);
        end
    endtask

    task automatic test_directed();
        ee = 1'b1; operand = 14'h0005; start = 1'b1;
        check_op(1'b1, 14'h0005, 1'b0, "ee1_op0005");
        ee = 1'b0; operand = 14'h2001; start = 1'b1;
        check_op(1'b0, 14'h2001, 1'b0, "ee0_op2001");
        ee = 1'b1; operand = 14'h0000; start = 1'b1;
        check_op(1'b1, 14'h0000, 1'b0, "ee1_op0000");
        ee = 1'b1; operand = 14'h2000; start = 1'b1;
        check_op(1'b1, 14'h2000, 1'b0, "ee1_op2000_full");
        ee = 1'b0; operand = 14'h0000; start = 1'b1;
        check_op(1'b0, 14'h0000, 1'b0, "ee0_op0000");
    endtask

    task automatic test_abort();
        ee = 1'b1; operand = 14'h3FFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (obs[9] !== 1'b1) begin
            errors++;
            $display("FAIL abort_load: load_en got %b expected 1", obs[9]);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== mk(0, 1, 0, 1, 1, 0, i)) begin
                errors++;
                $display("FAIL abort_step%0d: got %b expected %b", i, obs, mk(0, 1, 0, 1, 1, 0, i));
            end
        end
        @(posedge clk); #1;
        abort = 1'b1;
        #1;
        checks++;
        if ((obs & 10'h3D0) !== 10'h000) begin
            errors++;
            $display("FAIL abort_strobes: got %b expected strobes 0", obs);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (obs !== 10'h000) begin
            errors++;
            $display("FAIL abort_idle: got %b expected %b", obs, 10'h000);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== 10'h000) begin
                errors++;
                $display("FAIL abort_no_done%0d: got %b expected %b", i, obs, 10'h000);
            end
        end
    endtask

    task automatic test_back_to_back();
        ee = 1'b1; operand = 14'h0005; start = 1'b1;
        check_op(1'b1, 14'h0005, 1'b1, "b2b_first");
        operand = 14'h0003;
        check_op(1'b1, 14'h0003, 1'b0, "b2b_second");
        ee = 1'b0; operand = 14'h1234; start = 1'b1;
        check_op(1'b0, 14'h1234, 1'b1, "b2b_ee0_first");
        operand = 14'h0001;
        check_op(1'b0, 14'h0001, 1'b0, "b2b_ee0_second");
    endtask

    task automatic test_async_reset();
        ee = 1'b0; operand = 14'h3FFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 10'h000) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", obs, 10'h000);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== 10'h000) begin
                errors++;
                $display("FAIL post_reset_idle%0d: got %b expected %b", i, obs, 10'h000);
            end
        end
        operand = 14'h0009; start = 1'b1;
        check_op(1'b0, 14'h0009, 1'b0, "after_reset_op");
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        bit e;
        for (int t = 0; t < 12; t++) begin
            v = N'($urandom_range(0, (1 << N) - 1));
            if (t % 4 == 1) v = v & 14'h00FF;
            e = 1'($urandom_range(0, 1));
            ee = e; operand = v; start = 1'b1;
            check_op(e, v, 1'b0, $sformatf("rand%0d_ee%0d_%h", t, e, v));
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ee = 1'b1;
        operand = '0;
        #12;
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
